exp_sweep_checker: RTL and testbench
====================================

Name: exp_sweep_checker

Overview:
- Sequential stimulus/response engine for the 3-input combinational expression blocks (e.g. s = a & ~(b & c)).
- On `start` it drives every input vector in ascending order to the device under test (DUT) and holds each one for a settle time.
- It samples the DUT output at the end of each hold, compares it against a golden truth table and reports the mismatch count and first failing vector.
- Sits next to the expression module in synthesizable self-check harnesses; it replaces the hand-written initial-block sweeps.

Parameters:
- N_IN, 3, number of DUT inputs; the sweep covers 2^N_IN vectors.
- EXPECTED, 8'b0111_0000, golden truth table; bit i is the expected DUT output for vector i. Width is 2^N_IN. The default encodes a & ~(b & c) with vector = {a,b,c}.
- SETTLE, 1, number of cycles each vector is held before sampling; legal range ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- stim  output  N_IN  vector driven to the DUT; stim[N_IN-1] = a, stim[0] = c.
- resp  input  1  DUT output s, combinational from stim.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last sweep had zero mismatches; held until the next start is accepted.
- err_count  output  N_IN+1  number of mismatches in the current or last sweep.
- first_fail_valid  output  1  high when at least one mismatch has been recorded.
- first_fail_vec  output  N_IN  lowest vector that mismatched; valid only while first_fail_valid = 1.

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - State goes to IDLE.
  - stim=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0, first_fail_vec=0, settle counter=0.
- IDLE:
  - stim=0.
  - start=1 at edge k → state APPLY at k. busy=1 from cycle k+1.
  - Also at edge k: stim=0, counter=SETTLE-1, and err_count, pass, first_fail_valid and first_fail_vec are all cleared.
- APPLY:
  - stim holds the current vector.
  - counter≠0: decrement.
  - counter=0: sample resp at this edge. A mismatch is resp ≠ EXPECTED[stim].
  - On a mismatch:
    - err_count += 1.
    - If first_fail_valid = 0: set first_fail_valid = 1 and first_fail_vec = stim.
  - Then, if stim = 2^N_IN-1, go to FINISH; otherwise stim += 1 and counter = SETTLE-1.
- FINISH (exactly one cycle):
  - done=1 and busy=0.
  - pass = (err_count == 0), computed including the final sample.
  - stim returns to 0. Next state is IDLE.
- Latency: start accepted at edge k → done high in cycle k+1+2^N_IN·SETTLE. With the defaults, done is high in cycle k+9.
- Each vector is driven for exactly SETTLE cycles; there are no gaps between vectors.
- start while busy or in FINISH: ignored, with no restart.
- start at the same edge as reset: reset wins.
- Reset mid-sweep: abort immediately to reset values; no done pulse.
- err_count never overflows, because its maximum is 2^N_IN and it is N_IN+1 bits wide.
- resp is sampled only at counter=0 edges. resp in any other cycle is don't-care.

Decomposition:
- Shared package: state encoding (IDLE, APPLY, FINISH), the default EXPECTED constant for each expression exercise, and N_IN.
- One sub-module is natural: sweep_settle_timer, a loadable down-counter with a zero flag of width clog2(SETTLE)+1.
- The FSM, vector counter and scoreboard stay in exp_sweep_checker.

Test Plan:
- Defaults, resp driven by a correct a&~(b&c) DUT, start at edge k → stim steps 0..7, one value per cycle; done in cycle k+9; pass=1; err_count=0; first_fail_valid=0.
- resp stuck at 0 → err_count=3, first_fail_vec=4, pass=0.
- resp = ~(correct) → err_count=8, first_fail_vec=0, first_fail_valid=1, pass=0.
- SETTLE=3 with a correct DUT → each vector held 3 cycles; done in cycle k+25; pass=1.
- start pulsed again at stim=2 → ignored; single done at k+9. Then a new start clears pass/err_count at its accepting edge and a second sweep completes.
- reset asserted while stim=3 with a stuck-at-0 DUT → next cycle all outputs are 0 and there is no done. A fresh start then gives err_count=3 (not cumulative).

Source files
------------

// File: rtl/exp_sweep_checker_pkg.sv
// Shared definitions for the expression sweep checker: sweep state encoding,
// default input count and golden truth tables for the 3-input exercises.
package exp_sweep_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_FINISH = 2'd2
    } sweep_state_t;

    localparam int SWEEP_N_IN = 3;

    // Truth tables, bit i = expected output for vector i = {a,b,c}.
    localparam logic [7:0] EXPECTED_A_NAND_BC = 8'b0111_0000;  // a & ~(b & c)
    localparam logic [7:0] EXPECTED_AND3      = 8'b1000_0000;  // a & b & c
    localparam logic [7:0] EXPECTED_OR3       = 8'b1111_1110;  // a | b | c
    localparam logic [7:0] EXPECTED_XOR3      = 8'b1001_0110;  // a ^ b ^ c

    // Width of a settle down-counter able to hold SETTLE-1, plus one spare bit.
    function automatic int settle_width(input int settle);
        return $clog2(settle) + 1;
    endfunction

endpackage

// File: rtl/exp_sweep_checker_sweep_settle_timer.sv
// Loadable down-counter that paces each stimulus vector; zero marks the
// cycle in which the response is sampled.
module sweep_settle_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Load has priority over decrement; the counter saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/exp_sweep_checker.sv
// Exhaustive stimulus/response checker for small combinational expression
// blocks: walks every input vector, samples the response after a settle
// time and scores it against a golden truth table.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start, stim parked at 0
// ST_APPLY  | driving current vector, sampling resp when the timer hits 0
// ST_FINISH | one-cycle done pulse, pass/err_count final
module exp_sweep_checker
    import exp_sweep_checker_pkg::*;
#(
    parameter int                    N_IN     = SWEEP_N_IN,
    parameter logic [(2**N_IN)-1:0]  EXPECTED = EXPECTED_A_NAND_BC,
    parameter int                    SETTLE   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_fail_valid,
    output logic [N_IN-1:0] first_fail_vec
);

    localparam int            TW     = settle_width(SETTLE);
    localparam logic [TW-1:0] RELOAD = TW'(SETTLE - 1);

    sweep_state_t  state, state_next;
    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_count;
    logic          sample, mismatch, last_vec;
    logic [N_IN:0] err_next;

    sweep_settle_timer #(
        .W (TW)
    ) u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    assign last_vec = (stim == {N_IN{1'b1}});
    assign mismatch = sample && (resp != EXPECTED[stim]);
    assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

    // Next-state and timer control; a sample happens only when the timer is at zero.
    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        sample     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_APPLY;
                    tmr_load   = 1'b1;
                end
            end
            ST_APPLY: begin
                if (tmr_zero) begin
                    sample = 1'b1;
                    if (last_vec) begin
                        state_next = ST_FINISH;
                    end else begin
                        tmr_load = 1'b1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Vector counter and scoreboard. The verdict is registered on the last
    // sample edge so pass is already valid during the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim             <= '0;
            err_count        <= '0;
            pass             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stim <= '0;
                    if (start) begin
                        err_count        <= '0;
                        pass             <= 1'b0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                    end
                end
                ST_APPLY: begin
                    if (sample) begin
                        err_count <= err_next;
                        if (mismatch && !first_fail_valid) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= stim;
                        end
                        if (last_vec) begin
                            pass <= (err_next == '0);
                            stim <= '0;
                        end else begin
                            stim <= stim + 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    stim <= '0;
                end
                default: begin
                    stim <= '0;
                end
            endcase
        end
    end

    assign busy = (state == ST_APPLY);
    assign done = (state == ST_FINISH);

endmodule

// File: tb/tb_exp_sweep_checker.sv
// Self-checking bench: two checkers (SETTLE=1 and SETTLE=3) driven by a
// truth-table-defined DUT model, scored against an arithmetic reference.
module tb_exp_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    int         sel   = 0;
    logic [7:0] tbl   = 8'h00;

    logic [2:0] stim1, stim3, ffvec1, ffvec3;
    logic       resp1, resp3, busy1, busy3, done1, done3, pass1, pass3, ffv1, ffv3;
    logic [3:0] err1, err3;
    logic       start1, start3;

    assign start1 = start && (sel == 0);
    assign start3 = start && (sel == 1);
    assign resp1  = tbl[stim1];
    assign resp3  = tbl[stim3];

    exp_sweep_checker u_dut1 (
        .clk (clk), .reset (reset), .start (start1), .stim (stim1), .resp (resp1),
        .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
        .first_fail_valid (ffv1), .first_fail_vec (ffvec1)
    );

    exp_sweep_checker #(.SETTLE(3)) u_dut3 (
        .clk (clk), .reset (reset), .start (start3), .stim (stim3), .resp (resp3),
        .busy (busy3), .done (done3), .pass (pass3), .err_count (err3),
        .first_fail_valid (ffv3), .first_fail_vec (ffvec3)
    );

    logic [2:0] cur_stim, cur_ffvec;
    logic       cur_busy, cur_done, cur_pass, cur_ffv;
    logic [3:0] cur_err;

    always_comb begin
        cur_stim  = stim1;  cur_busy = busy1;  cur_done = done1;  cur_pass = pass1;
        cur_err   = err1;   cur_ffv  = ffv1;   cur_ffvec = ffvec1;
        if (sel == 1) begin
            cur_stim  = stim3;  cur_busy = busy3;  cur_done = done3;  cur_pass = pass3;
            cur_err   = err3;   cur_ffv  = ffv3;   cur_ffvec = ffvec3;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: golden output is a & ~(b & c) with vector = {a,b,c}.
    task automatic model(input logic [7:0] t, output int e, output int f);
        e = 0;
        f = -1;
        for (int v = 0; v < 8; v++) begin
            int a, b, c, g;
            a = (v / 4) % 2;
            b = (v / 2) % 2;
            c = v % 2;
            g = a * (1 - b * c);
            if (int'(t[v]) != g) begin
                e++;
                if (f < 0) f = v;
            end
        end
    endtask

    task automatic run_sweep(input int s, input logic [7:0] t, input string tag,
                             input int restart_at);
        int settle, c, stim_bad, busy_bad, e, f;
        bit pulsed;
        settle   = (s == 1) ? 3 : 1;
        stim_bad = 0;
        busy_bad = 0;
        pulsed   = 0;
        sel = s;
        tbl = t;
        model(t, e, f);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, ".clr_err"}, 32'(cur_err), 0);
        chk({tag, ".clr_pass"}, 32'(cur_pass), 0);
        chk({tag, ".clr_ffv"}, 32'(cur_ffv), 0);
        c = 1;
        while (!cur_done && c < 8 * settle + 10) begin
            if (int'(cur_stim) != (c - 1) / settle) stim_bad++;
            if (!cur_busy) busy_bad++;
            if (restart_at >= 0 && !pulsed && int'(cur_stim) == restart_at) begin
                start  = 1'b1;
                pulsed = 1;
            end
            tick();
            start = 1'b0;
            c++;
        end
        chk({tag, ".latency"}, 32'(c), 32'(1 + 8 * settle));
        chk({tag, ".stim_seq_errs"}, 32'(stim_bad), 0);
        chk({tag, ".busy_gaps"}, 32'(busy_bad), 0);
        chk({tag, ".done"}, 32'(cur_done), 1);
        chk({tag, ".busy_at_done"}, 32'(cur_busy), 0);
        chk({tag, ".pass"}, 32'(cur_pass), 32'(e == 0));
        chk({tag, ".err_count"}, 32'(cur_err), 32'(e));
        chk({tag, ".ffv"}, 32'(cur_ffv), 32'(e != 0));
        if (e != 0) chk({tag, ".ffvec"}, 32'(cur_ffvec), 32'(f));
        chk({tag, ".stim_at_done"}, 32'(cur_stim), 0);
        tick();
        chk({tag, ".done_pulse"}, 32'(cur_done), 0);
        chk({tag, ".pass_held"}, 32'(cur_pass), 32'(e == 0));
        chk({tag, ".err_held"}, 32'(cur_err), 32'(e));
        chk({tag, ".idle_busy"}, 32'(cur_busy), 0);
    endtask

    logic [7:0] correct;
    int         n, ndone;
    int         stops[2] = '{3, 6};

    initial begin
        model(8'h00, n, ndone);
        correct = 8'b0111_0000;

        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("rst.stim", 32'(cur_stim), 0);
            chk("rst.busy", 32'(cur_busy), 0);
            chk("rst.done", 32'(cur_done), 0);
            chk("rst.pass", 32'(cur_pass), 0);
            chk("rst.err", 32'(cur_err), 0);
            chk("rst.ffv", 32'(cur_ffv), 0);
            chk("rst.ffvec", 32'(cur_ffvec), 0);
        end
        reset = 1'b0;
        tick();

        run_sweep(0, correct, "good1", -1);
        run_sweep(0, 8'h00, "stuck0", -1);
        run_sweep(0, ~correct, "invert", -1);
        run_sweep(1, correct, "good3", -1);
        run_sweep(1, 8'h00, "stuck0_s3", -1);
        run_sweep(0, correct, "restart", 2);
        run_sweep(0, 8'h00, "after_restart", -1);

        for (int i = 0; i < 2; i++) begin
            sel = 0;
            tbl = 8'h00;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (int'(cur_stim) != stops[i] && n < 20) begin
                tick();
                n++;
            end
            chk("midrst.reach_stop", 32'(n < 20), 1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk("midrst.stim", 32'(cur_stim), 0);
            chk("midrst.busy", 32'(cur_busy), 0);
            chk("midrst.done", 32'(cur_done), 0);
            chk("midrst.err", 32'(cur_err), 0);
            chk("midrst.ffv", 32'(cur_ffv), 0);
            chk("midrst.ffvec", 32'(cur_ffvec), 0);
            chk("midrst.pass", 32'(cur_pass), 0);
            ndone = 0;
            for (int k = 0; k < 12; k++) begin
                if (cur_done) ndone++;
                tick();
            end
            chk("midrst.no_done", 32'(ndone), 0);
            run_sweep(0, 8'h00, "post_rst", -1);
        end

        sel = 0;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_vs_start.busy", 32'(cur_busy), 0);
        tick();
        chk("rst_vs_start.busy2", 32'(cur_busy), 0);

        for (int i = 0; i < 8; i++) begin
            logic [7:0] rt;
            rt = 8'($urandom_range(0, 255));
            run_sweep(i % 2, rt, $sformatf("rand%0d", i), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
